// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART FIFO slice (control unit, register_file, FIFO top).
package uart_fifo_pkg;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;

endpackage : uart_fifo_pkg

// File: rtl/fifo_control_unit_if.sv
// Handshake and status bundle between the FIFO producer/consumer and the control unit.
interface fifo_control_unit_if
  import uart_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_ADDR_W
);

  logic             push;
  logic             pop;
  logic             wr_en;
  logic [WIDTH-1:0] w_ptr;
  logic [WIDTH-1:0] r_ptr;
  logic             full;
  logic             empty;
  logic [WIDTH:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop,
    input  wr_en, w_ptr, r_ptr, full, empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop,
    output wr_en, w_ptr, r_ptr, full, empty, count, overflow, underflow
  );

endinterface : fifo_control_unit_if

// File: rtl/fifo_control_unit.sv
// Pointer, occupancy and flag control for a DEPTH-entry FIFO with zero-latency reads.
module fifo_control_unit
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_ADDR_W
) (
  input logic                 clk,
  input logic                 rst_n,
  fifo_control_unit_if.slave  bus
);

  localparam int CNT_W = WIDTH + 1;

  logic [WIDTH-1:0] w_ptr_r;
  logic [WIDTH-1:0] r_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             push_ok_s;
  logic             pop_ok_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Accept qualification and next occupancy; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    push_ok_s   = bus.push & (~full_r | bus.pop) & rst_n;
    pop_ok_s    = bus.pop & ~empty_r;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and flag registers; pointers wrap naturally since DEPTH == 2**WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_r     <= '0;
      r_ptr_r     <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        w_ptr_r <= w_ptr_r + WIDTH'(1);
      end else begin
        w_ptr_r <= w_ptr_r;
      end
      if (pop_ok_s) begin
        r_ptr_r <= r_ptr_r + WIDTH'(1);
      end else begin
        r_ptr_r <= r_ptr_r;
      end
      count_r     <= count_nxt_s;
      full_r      <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r     <= (count_nxt_s == CNT_W'(0));
      overflow_r  <= bus.push & ~bus.pop & full_r;
      underflow_r <= bus.pop & ~bus.push & empty_r;
    end
  end

  assign bus.wr_en     = push_ok_s;
  assign bus.w_ptr     = w_ptr_r;
  assign bus.r_ptr     = r_ptr_r;
  assign bus.count     = count_r;
  assign bus.full      = full_r;
  assign bus.empty     = empty_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

endmodule : fifo_control_unit

// File: tb/tb_fifo_control_unit.sv
// Directed and random bench for fifo_control_unit against an occupancy/pointer reference model.
module tb_fifo_control_unit;

  localparam int DEPTH = 16;
  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;

  fifo_control_unit_if #(.WIDTH(WIDTH)) bus ();

  fifo_control_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: occupancy and pointers as plain integers.
  int occ = 0;
  int wp  = 0;
  int rp  = 0;
  int ov  = 0;
  int un  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ = 0; wp = 0; rp = 0; ov = 0; un = 0;
  endtask

  task automatic check_state(input string where);
    int diff;
    chk({where, ".w_ptr"}, 32'(bus.w_ptr), 32'(wp));
    chk({where, ".r_ptr"}, 32'(bus.r_ptr), 32'(rp));
    chk({where, ".count"}, 32'(bus.count), 32'(occ));
    chk({where, ".full"}, 32'(bus.full), 32'(occ == DEPTH));
    chk({where, ".empty"}, 32'(bus.empty), 32'(occ == 0));
    chk({where, ".overflow"}, 32'(bus.overflow), 32'(ov));
    chk({where, ".underflow"}, 32'(bus.underflow), 32'(un));
    diff = (int'(bus.w_ptr) - int'(bus.r_ptr) + DEPTH) % DEPTH;
    if (bus.full === 1'b1) diff = DEPTH;
    chk({where, ".ptr_diff"}, 32'(bus.count), 32'(diff));
    chk({where, ".full_and_empty"}, 32'(bus.full & bus.empty), 32'd0);
  endtask

  task automatic step(input string where, input bit p, input bit q);
    bit acc_push;
    bit acc_pop;
    @(negedge clk);
    bus.push = p;
    bus.pop  = q;
    acc_push = p && (occ < DEPTH || q);
    acc_pop  = q && (occ > 0);
    #1;
    chk({where, ".wr_en"}, 32'(bus.wr_en), 32'(acc_push));
    @(posedge clk);
    ov  = (p && !q && occ == DEPTH) ? 1 : 0;
    un  = (q && !p && occ == 0) ? 1 : 0;
    occ = occ + int'(acc_push) - int'(acc_pop);
    wp  = (wp + int'(acc_push)) % DEPTH;
    rp  = (rp + int'(acc_pop)) % DEPTH;
    #1;
    check_state(where);
  endtask

  // Drop rst_n mid-cycle with push held high, check the immediate effect, then release.
  task automatic async_reset(input string where);
    @(negedge clk);
    bus.push = 1'b1;
    bus.pop  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({where, ".wr_en_in_reset"}, 32'(bus.wr_en), 32'd0);
    check_state(where);
    @(negedge clk);
    bus.push = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Build occupancy of 5, then reset asynchronously.
    for (int i = 0; i < 5; i++) step("prefill", 1'b1, 1'b0);
    chk("prefill.count5", 32'(bus.count), 32'd5);
    async_reset("midreset");

    // Underflow and push&pop while empty.
    step("underflow", 1'b0, 1'b1);
    chk("underflow.pulse", 32'(bus.underflow), 32'd1);
    step("underflow_clear", 1'b0, 1'b0);
    step("pushpop_empty", 1'b1, 1'b1);
    chk("pushpop_empty.count", 32'(bus.count), 32'd1);
    chk("pushpop_empty.w_ptr", 32'(bus.w_ptr), 32'd1);
    step("drain", 1'b0, 1'b1);

    // Fill from a clean reset so w_ptr wraps 15->0.
    async_reset("prefill_reset");
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0);
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.w_ptr_wrap", 32'(bus.w_ptr), 32'd0);

    // Overflow pulse lasts one cycle.
    step("overflow", 1'b1, 1'b0);
    chk("overflow.pulse", 32'(bus.overflow), 32'd1);
    step("overflow_clear", 1'b0, 1'b0);

    // Push and pop together while full.
    step("full_pushpop", 1'b1, 1'b1);
    chk("full_pushpop.count", 32'(bus.count), 32'd16);

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset from an arbitrary random state, then resume.
    async_reset("final_reset");
    step("post_reset_push", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_control_unit
